// File: rtl/apb_master_nslv.sv
// APB3 requester: valid/ready request port to NSLV slaves with address decode,
// per-slave response muxing and an ACCESS wait-state timeout.
module apb_master_nslv #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 8,
   parameter int NSLV    = 2,
   parameter int TIMEOUT = 16
) (
   input  logic                   pclk,
   input  logic                   presetn,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [DATA_W-1:0]      req_wdata,
   output logic                   rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   rsp_err,
   output logic [ADDR_W-1:0]      paddr,
   output logic                   pwrite,
   output logic [DATA_W-1:0]      pwdata,
   output logic [NSLV-1:0]        psel,
   output logic                   penable,
   input  logic [NSLV*DATA_W-1:0] prdata,
   input  logic [NSLV-1:0]        pready,
   input  logic [NSLV-1:0]        pslverr
);

   localparam int SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [SEL_W-1:0]  idx;
   logic              dec_ok;
   logic              sel_rdy, sel_err;
   logic [DATA_W-1:0] sel_rdata;

   logic              rsp_valid_nxt, rsp_err_nxt, pwrite_nxt, penable_nxt;
   logic [DATA_W-1:0] rsp_rdata_nxt, pwdata_nxt;
   logic [ADDR_W-1:0] paddr_nxt;
   logic [NSLV-1:0]   psel_nxt;

   assign req_ready = (state == IDLE);

   always_comb begin
      idx    = '0;
      if (NSLV > 1) idx = req_addr[ADDR_W-1 -: SEL_W];
      dec_ok = int'(idx) < NSLV;
   end

   // psel is one-hot, so it doubles as the response mux select
   always_comb begin
      sel_rdy   = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (psel[i]) begin
            sel_rdy   = pready[i];
            sel_err   = pslverr[i];
            sel_rdata = prdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      rsp_valid_nxt = 1'b0;
      rsp_err_nxt   = rsp_err;
      rsp_rdata_nxt = rsp_rdata;
      paddr_nxt     = paddr;
      pwrite_nxt    = pwrite;
      pwdata_nxt    = pwdata;
      psel_nxt      = psel;
      penable_nxt   = penable;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               paddr_nxt  = req_addr;
               pwrite_nxt = req_write;
               pwdata_nxt = req_wdata;
               if (dec_ok) begin
                  state_nxt = SETUP;
                  cnt_nxt   = '0;
                  for (int i = 0; i < NSLV; i++)
                     psel_nxt[i] = (int'(idx) == i);
               end else begin
                  rsp_valid_nxt = 1'b1;
                  rsp_err_nxt   = 1'b1;
                  rsp_rdata_nxt = '0;
               end
            end
         end
         SETUP: begin
            state_nxt   = ACCESS;
            penable_nxt = 1'b1;
         end
         ACCESS: begin
            if (sel_rdy) begin
               state_nxt     = IDLE;
               psel_nxt      = '0;
               penable_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = sel_err;
               rsp_rdata_nxt = (!pwrite && !sel_err) ? sel_rdata : '0;
            end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
               state_nxt     = IDLE;
               psel_nxt      = '0;
               penable_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b1;
               rsp_rdata_nxt = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state     <= IDLE;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         paddr     <= '0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
         psel      <= '0;
         penable   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_err   <= rsp_err_nxt;
         rsp_rdata <= rsp_rdata_nxt;
         paddr     <= paddr_nxt;
         pwrite    <= pwrite_nxt;
         pwdata    <= pwdata_nxt;
         psel      <= psel_nxt;
         penable   <= penable_nxt;
      end
   end

endmodule

// File: tb/tb_apb_master_nslv.sv
// Directed bench: instance A uses defaults, instance B has NSLV=3 and no
// timeout.
module tb_apb_master_nslv;

   logic        pclk = 1'b0;
   logic        presetn;
   logic        va, vb;
   logic        req_write;
   logic [8:0]  req_addr;
   logic [7:0]  req_wdata;

   logic        ra_ready, ra_valid, ra_err, a_pwrite, a_penable;
   logic [7:0]  ra_rdata, a_pwdata;
   logic [8:0]  a_paddr;
   logic [1:0]  a_psel, a_pready, a_pslverr;
   logic [15:0] a_prdata;

   logic        rb_ready, rb_valid, rb_err, b_pwrite, b_penable;
   logic [7:0]  rb_rdata, b_pwdata;
   logic [8:0]  b_paddr;
   logic [2:0]  b_psel, b_pready, b_pslverr;
   logic [23:0] b_prdata;

   int n_cmp = 0;
   int n_err = 0;
   int pen_cnt;

   always #5 pclk = ~pclk;

   apb_master_nslv dut_a (
      .pclk(pclk), .presetn(presetn),
      .req_valid(va), .req_ready(ra_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(ra_valid), .rsp_rdata(ra_rdata), .rsp_err(ra_err),
      .paddr(a_paddr), .pwrite(a_pwrite), .pwdata(a_pwdata),
      .psel(a_psel), .penable(a_penable),
      .prdata(a_prdata), .pready(a_pready), .pslverr(a_pslverr)
   );

   apb_master_nslv #(.NSLV(3), .TIMEOUT(0)) dut_b (
      .pclk(pclk), .presetn(presetn),
      .req_valid(vb), .req_ready(rb_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rb_valid), .rsp_rdata(rb_rdata), .rsp_err(rb_err),
      .paddr(b_paddr), .pwrite(b_pwrite), .pwdata(b_pwdata),
      .psel(b_psel), .penable(b_penable),
      .prdata(b_prdata), .pready(b_pready), .pslverr(b_pslverr)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   initial begin
      presetn   = 1'b0;
      va        = 1'b0;
      vb        = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      a_pready  = '0;
      a_pslverr = '0;
      a_prdata  = '0;
      b_pready  = '0;
      b_pslverr = '0;
      b_prdata  = '0;
      step();
      step();
      chk("rst_ready", ra_ready, 1);
      chk("rst_valid", ra_valid, 0);
      chk("rst_psel", a_psel, 0);
      chk("rst_penable", a_penable, 0);
      chk("rst_paddr", a_paddr, 0);
      chk("rst_rdata", ra_rdata, 0);
      chk("rst_b_psel", b_psel, 0);
      presetn = 1'b1;
      step();

      // zero-wait write to slave 0
      va = 1'b1; req_write = 1'b1; req_addr = 9'h012; req_wdata = 8'hA5;
      a_pready = 2'b01;
      step();
      va = 1'b0;
      chk("wr_setup_psel", a_psel, 2'b01);
      chk("wr_setup_pen", a_penable, 0);
      chk("wr_pwdata", a_pwdata, 8'hA5);
      chk("wr_paddr", a_paddr, 9'h012);
      chk("wr_pwrite", a_pwrite, 1);
      chk("wr_busy", ra_ready, 0);
      step();
      chk("wr_access_pen", a_penable, 1);
      chk("wr_access_vld", ra_valid, 0);
      step();
      chk("wr_rsp_vld", ra_valid, 1);
      chk("wr_rsp_err", ra_err, 0);
      chk("wr_rsp_rdata", ra_rdata, 0);
      chk("wr_done_psel", a_psel, 0);
      chk("wr_done_pen", a_penable, 0);
      step();
      chk("wr_pulse_end", ra_valid, 0);

      // read slave 1 with 2 wait states; slave 0 ready is ignored
      va = 1'b1; req_write = 1'b0; req_addr = 9'h134;
      a_pready = 2'b01; a_prdata = {8'h3C, 8'h77};
      step();
      va = 1'b0;
      chk("rd_psel", a_psel, 2'b10);
      step();
      chk("rd_pen1", a_penable, 1);
      step();
      chk("rd_wait1", {a_penable, ra_valid}, 2'b10);
      step();
      chk("rd_wait2", {a_penable, ra_valid}, 2'b10);
      a_pready = 2'b11;
      step();
      chk("rd_rsp_vld", ra_valid, 1);
      chk("rd_rsp_rdata", ra_rdata, 8'h3C);
      chk("rd_rsp_err", ra_err, 0);
      chk("b2b_ready", ra_ready, 1);

      // back-to-back read of slave 1 ending in pslverr
      va = 1'b1; req_addr = 9'h100;
      a_pready = 2'b10; a_pslverr = 2'b10; a_prdata = {8'hFF, 8'h00};
      step();
      va = 1'b0;
      chk("err_psel", a_psel, 2'b10);
      chk("err_no_vld", ra_valid, 0);
      step();
      step();
      chk("err_rsp_vld", ra_valid, 1);
      chk("err_rsp_err", ra_err, 1);
      chk("err_rsp_rdata", ra_rdata, 0);
      a_pslverr = 2'b00;
      step();

      // timeout on slave 0
      va = 1'b1; req_write = 1'b1; req_addr = 9'h000; req_wdata = 8'h44;
      a_pready = 2'b00;
      step();
      va = 1'b0;
      pen_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (ra_valid) break;
         if (a_penable) pen_cnt++;
      end
      chk("to_rsp_vld", ra_valid, 1);
      chk("to_pen_cycles", pen_cnt, 16);
      chk("to_rsp_err", ra_err, 1);
      chk("to_rsp_rdata", ra_rdata, 0);
      chk("to_psel", a_psel, 0);
      step();

      // reset in ACCESS
      va = 1'b1; req_write = 1'b1; req_addr = 9'h0AA; req_wdata = 8'h5A;
      step();
      va = 1'b0;
      step();
      chk("mid_access", a_penable, 1);
      presetn = 1'b0;
      #1;
      chk("arst_psel", a_psel, 0);
      chk("arst_pen", a_penable, 0);
      chk("arst_paddr", a_paddr, 0);
      chk("arst_pwdata", a_pwdata, 0);
      chk("arst_err", ra_err, 1'b0);
      step();
      chk("arst_no_vld", ra_valid, 0);
      presetn = 1'b1;
      step();

      // back-to-back writes after reset
      a_pready = 2'b01;
      va = 1'b1; req_addr = 9'h011; req_wdata = 8'h11;
      step();
      va = 1'b0;
      chk("bb1_psel", a_psel, 2'b01);
      step();
      step();
      chk("bb1_vld", ra_valid, 1);
      chk("bb1_ready", ra_ready, 1);
      va = 1'b1; req_addr = 9'h022; req_wdata = 8'h22;
      step();
      va = 1'b0;
      chk("bb2_psel", a_psel, 2'b01);
      chk("bb2_pwdata", a_pwdata, 8'h22);
      step();
      step();
      chk("bb2_vld", {ra_valid, ra_err}, 2'b10);
      step();

      // NSLV=3 decode error, then a read that stalls without timeout
      vb = 1'b1; req_write = 1'b0; req_addr = 9'h1C0;
      step();
      chk("dec_psel", b_psel, 0);
      chk("dec_vld", rb_valid, 1);
      chk("dec_err", rb_err, 1);
      chk("dec_ready", rb_ready, 1);
      req_addr = 9'h080;
      b_pready = 3'b101;
      b_prdata = {8'h00, 8'h5E, 8'h99};
      step();
      vb = 1'b0;
      chk("b_psel", b_psel, 3'b010);
      chk("b_no_vld", rb_valid, 0);
      for (int i = 0; i < 30; i++) step();
      chk("stall_pen", {b_penable, b_psel, rb_valid}, 5'b1_010_0);
      b_pready = 3'b010;
      step();
      chk("b_rsp", {rb_valid, rb_err}, 2'b10);
      chk("b_rdata", rb_rdata, 8'h5E);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/apb_master_nslv.md
# apb_master_nslv

Parametrised APB requester that turns a simple valid/ready request port into APB3 transfers across NSLV slaves. It generalises the fixed two-slave master/slave pairing with configurable address and data widths and any slave count. It adds address decode with decode-error reporting, per-slave prdata/pready/pslverr muxing, and a wait-state timeout. It sits between a local controller and the APB slave fabric, one instance per APB segment.

## Interface
- ADDR_W, 9: paddr width; the top SEL_W = $clog2(NSLV) bits select the slave.
- DATA_W, 8: pwdata/prdata width.
- NSLV, 2: number of slaves, ≥1. When NSLV=1, every address decodes to slave 0.
- TIMEOUT, 16: maximum ACCESS wait cycles with pready low before abort. 0 disables the timeout.

Ports (name, direction, width, meaning):
- pclk  in  1  sole clock, rising edge.
- presetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; equals (state==IDLE).
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  error flag, qualified by rsp_valid.
- paddr  out  ADDR_W  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- psel  out  NSLV  one-hot slave select.
- penable  out  1  APB access phase.
- prdata  in  NSLV*DATA_W  slave i occupies bits [i*DATA_W +: DATA_W].
- pready  in  NSLV  per-slave ready.
- pslverr  in  NSLV  per-slave error.

## Operation
- FSM states are IDLE, SETUP and ACCESS. Reset enters IDLE.
- IDLE:
  - If req_valid && req_ready, register req_write, req_addr and req_wdata into pwrite, paddr and pwdata.
  - Decode idx = req_addr[ADDR_W-1 -: SEL_W], or 0 when NSLV=1.
  - If idx < NSLV, go to SETUP with psel[idx]=1.
  - If idx ≥ NSLV, this is a decode error: return to IDLE with rsp_valid=1, rsp_err=1, rsp_rdata=0. psel and penable are never asserted.
- SETUP: psel[idx]=1, penable=0. Unconditionally go to ACCESS.
- ACCESS: psel[idx]=1, penable=1.
  - If pready[idx]=1, the transfer completes. Go to IDLE; on the next cycle rsp_valid=1 and rsp_err=pslverr[idx].
  - rsp_rdata = prdata slice idx when the transfer is a read with pslverr[idx]=0; otherwise 0.
  - If pready[idx]=0, increment the wait counter (width $clog2(TIMEOUT+1)).
  - When TIMEOUT≠0 and the counter reaches TIMEOUT with pready[idx] still 0, abort: go to IDLE with rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - The wait counter clears on entry to SETUP.
- Only the selected slave's pready, pslverr and prdata are observed. Other slaves' inputs are ignored.
- In IDLE: psel=0 and penable=0. paddr, pwrite and pwdata hold their last values.
- rsp_rdata and rsp_err hold until the next rsp_valid.

## Timing
- Reset values (all asynchronous): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, paddr=0, pwrite=0, pwdata=0, psel=0, penable=0, wait counter 0.
- All outputs are registered except req_ready, which is decoded from the state register.
- Zero-wait transfer:
  - Request accepted at edge E0.
  - SETUP is visible after E0.
  - ACCESS is visible after E1.
  - pready is sampled high at E2.
  - rsp_valid is high after E2 for exactly one cycle.
- Each extra wait cycle adds 1 to this latency.
- Back-to-back: req_ready=1 in the same cycle as rsp_valid. A request accepted then starts SETUP on the next cycle, giving 1 transfer per 3 cycles at zero wait.
- Decode error: rsp_valid is high in the cycle after acceptance; req_ready stays 1.
- Timeout: after E1, ACCESS occupies TIMEOUT cycles with pready low, then the block aborts. rsp_valid fires on the following cycle. Total request-to-response latency is TIMEOUT+2 edges.
- Reset asserted mid-transfer: psel and penable drop immediately and no rsp_valid is generated. The first request after deassertion is accepted normally.
- A pready from a non-selected slave has no effect.

## Test plan
All scenarios use defaults unless stated.
- Write 8'hA5 to 9'h012, slave 0 pready tied 1: psel=2'b01, penable high exactly 1 cycle, pwdata=8'hA5, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read 9'h134 with slave 1 returning 8'h3C after 2 wait cycles: psel=2'b10, penable high 3 cycles, rsp_rdata=8'h3C, latency 5.
- Read 9'h100 with slave 1 pslverr=1 at completion and prdata=8'hFF: rsp_err=1, rsp_rdata=0.
- NSLV=3, read 9'h1C0 (idx 3): psel stays 0, rsp_valid the next cycle with rsp_err=1. A following read of 9'h080 goes to psel=3'b010.
- Slave 0 pready held 0: after 16 ACCESS cycles psel and penable drop, rsp_err=1, rsp_rdata=0. With TIMEOUT=0 the transfer stalls indefinitely.
- presetn pulsed low during ACCESS: all outputs return to reset values, no rsp_valid. Then back-to-back writes are accepted in consecutive rsp_valid cycles.
